// File: rtl/rv_insn_encoder_packer_if.sv
// Request/response bundle between a stimulus source and rv_insn_encoder_packer.
// The master drives symbolic instructions and out_ready; the slave returns packed fetch words.
interface rv_insn_encoder_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_cmp_en;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_cmp_en, in_flush, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_cmp_en, in_flush, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rv_insn_encoder_packer.sv
// Encodes symbolic RV32I/RV32C instructions and packs the 16/32-bit encodings into a
// little-endian 32-bit fetch-word stream with a single-entry output register.
module rv_insn_encoder_packer #(
    parameter bit          RVC_EN   = 1'b1,
    parameter logic [15:0] PAD_HALF = 16'h0001
) (
    input logic                     clk,
    input logic                     rst_l,
    rv_insn_encoder_packer_if.slave bus
);

    typedef enum logic [0:0] {StEmpty, StHalf} state_e;

    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imm6_ok;

    assign op  = bus.in_op;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign imm = bus.in_imm;
    // Immediate fits a 6-bit signed RVC field, i.e. lies in [-32, 31].
    assign imm6_ok = (&imm[31:5]) | ~(|imm[31:5]);

    logic [31:0] w;
    logic        illegal;

    always_comb begin
        w       = '0;
        illegal = 1'b0;
        case (op)
            6'd0:  w = {imm[31:12], rd, 7'h37};
            6'd1:  w = {imm[31:12], rd, 7'h17};
            6'd2:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            6'd3:  w = {imm[11:0], rs1, 3'b000, rd, 7'h67};
            6'd4:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
            6'd5:  w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
            6'd6:  w = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], 7'h63};
            6'd7:  w = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], 7'h63};
            6'd8:  w = {imm[12], imm[10:5], rs2, rs1, 3'b110, imm[4:1], imm[11], 7'h63};
            6'd9:  w = {imm[12], imm[10:5], rs2, rs1, 3'b111, imm[4:1], imm[11], 7'h63};
            6'd10: w = {imm[11:0], rs1, 3'b010, rd, 7'h03};
            6'd11: w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            6'd12: w = {imm[11:0], rs1, 3'b000, rd, 7'h13};
            6'd13: w = {imm[11:0], rs1, 3'b010, rd, 7'h13};
            6'd14: w = {imm[11:0], rs1, 3'b011, rd, 7'h13};
            6'd15: w = {imm[11:0], rs1, 3'b100, rd, 7'h13};
            6'd16: w = {imm[11:0], rs1, 3'b110, rd, 7'h13};
            6'd17: w = {imm[11:0], rs1, 3'b111, rd, 7'h13};
            6'd18: w = {7'b0000000, imm[4:0], rs1, 3'b001, rd, 7'h13};
            6'd19: w = {7'b0000000, imm[4:0], rs1, 3'b101, rd, 7'h13};
            6'd20: w = {7'b0100000, imm[4:0], rs1, 3'b101, rd, 7'h13};
            6'd21: w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'h33};
            6'd22: w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'h33};
            6'd23: w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'h33};
            6'd24: w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'h33};
            6'd25: w = {7'b0000000, rs2, rs1, 3'b011, rd, 7'h33};
            6'd26: w = {7'b0000000, rs2, rs1, 3'b100, rd, 7'h33};
            6'd27: w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'h33};
            6'd28: w = {7'b0100000, rs2, rs1, 3'b101, rd, 7'h33};
            6'd29: w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'h33};
            6'd30: w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'h33};
            6'd31: w = 32'h0000_0073;
            6'd32: w = 32'h0010_0073;
            6'd33: w = 32'h3020_0073;
            6'd34: w = 32'h1050_0073;
            6'd35: w = {4'b0000, 4'b1111, 4'b1111, rs1, 3'b000, rd, 7'h0f};
            default: illegal = 1'b1;
        endcase
    end

    logic [15:0] c;
    logic        use_c;

    always_comb begin
        c     = '0;
        use_c = 1'b0;
        if (RVC_EN && bus.in_cmp_en) begin
            use_c = 1'b1;
            if (op == 6'd12 && rs1 == 5'd0 && rd != 5'd0 && imm6_ok) begin
                c = {3'b010, imm[5], rd, imm[4:0], 2'b01};
            end else if (op == 6'd12 && rd == rs1 && rd != 5'd0 && imm != 32'd0 && imm6_ok) begin
                c = {3'b000, imm[5], rd, imm[4:0], 2'b01};
            end else if (op == 6'd21 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                c = {4'b1001, rd, rs2, 2'b10};
            end else if (op == 6'd21 && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
                c = {4'b1000, rd, rs2, 2'b10};
            end else if (op == 6'd3 && rd == 5'd0 && rs1 != 5'd0 && imm == 32'd0) begin
                c = {4'b1000, rs1, 5'd0, 2'b10};
            end else if (op == 6'd32) begin
                c = 16'h9002;
            end else begin
                use_c = 1'b0;
            end
        end
    end

    state_e      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        err_q, err_d;
    logic        accept;

    assign bus.in_ready  = ~out_valid_q | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = err_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        if (accept) begin
            if (bus.in_flush) begin
                if (state_q == StHalf) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {PAD_HALF, pend_q};
                    state_d     = StEmpty;
                end
            end else begin
                err_d = illegal;
                // Illegal ops never compress: use_c requires a matched legal op.
                if (use_c) begin
                    if (state_q == StEmpty) begin
                        pend_d  = c;
                        state_d = StHalf;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = {c, pend_q};
                        state_d     = StEmpty;
                    end
                end else if (state_q == StEmpty) begin
                    out_valid_d = 1'b1;
                    out_data_d  = w;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = {w[15:0], pend_q};
                    pend_d      = w[31:16];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= StEmpty;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_rv_insn_encoder_packer.sv
// Directed bench for rv_insn_encoder_packer: hand-encoded RV32I/RVC words, packing,
// flush padding, backpressure, illegal-op pulse and mid-stream reset.
module tb_rv_insn_encoder_packer;

    logic clk;
    logic rst_l;
    int   n_asserts;
    int   n_fail;

    rv_insn_encoder_packer_if bus ();

    rv_insn_encoder_packer #(
        .RVC_EN   (1'b1),
        .PAD_HALF (16'h0001)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge and returns 1 time unit after its accept edge.
    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic cmp,
                        input logic flush);
        bit done;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_cmp_en = cmp;
        bus.in_flush  = flush;
        bus.in_valid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("send_timeout", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, "_data"}, bus.out_data, exp);
    endtask

    initial begin
        n_asserts     = 0;
        n_fail        = 0;
        rst_l         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.in_cmp_en = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // 1: ADDI x1,x0,5 uncompressed
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
        expect_word("t1_addi", 32'h0050_0093);
        @(negedge clk);
        check("t1_drained", {31'b0, bus.out_valid}, 32'd0);

        // 2: ADD x3,x1,x2 has no RVC form
        send(6'd21, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
        expect_word("t2_add", 32'h0020_81B3);

        // 3: two C.LI x1,5 pack into one word
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_no_word", {31'b0, bus.out_valid}, 32'd0);
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
        expect_word("t3_pair", 32'h4095_4095);

        // 4: C.LI; ADD splits across words; flush pads
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
        send(6'd21, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b0);
        expect_word("t4_split", 32'h81B3_4095);
        send(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        expect_word("t4_flush", 32'h0001_0020);
        send(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_empty_flush", {31'b0, bus.out_valid}, 32'd0);

        // 5: backpressure holds data and blocks input
        bus.out_ready = 1'b0;
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_op     = 6'd21;
        bus.in_rd     = 5'd3;
        bus.in_rs1    = 5'd1;
        bus.in_rs2    = 5'd2;
        bus.in_imm    = 32'd0;
        bus.in_cmp_en = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t5_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("t5_hold", bus.out_data, 32'h0050_0093);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        expect_word("t5_resume", 32'h0020_81B3);
        @(negedge clk);
        check("t5_no_dup", {31'b0, bus.out_valid}, 32'd0);

        // More encodings: RVC pairs and 32-bit formats
        send(6'd12, 5'd2, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(6'd21, 5'd3, 5'd0, 5'd1, 32'd0, 1'b1, 1'b0);
        expect_word("c_addi_mv", 32'h8186_117D);
        send(6'd3, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 1'b0);
        send(6'd21, 5'd2, 5'd2, 5'd3, 32'd0, 1'b1, 1'b0);
        expect_word("c_jr_add", 32'h910E_8082);
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
        send(6'd32, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        expect_word("c_ebreak", 32'h9002_4095);
        send(6'd4, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0);
        expect_word("beq", 32'h0020_8463);
        send(6'd11, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0, 1'b0);
        expect_word("sw", 32'h0020_A223);
        send(6'd20, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0, 1'b0);
        expect_word("srai", 32'h4033_5293);
        send(6'd2, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b0);
        expect_word("jal", 32'h0100_00EF);
        send(6'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b0);
        expect_word("lui", 32'h1234_52B7);
        send(6'd33, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
        expect_word("mret", 32'h3020_0073);

        // 6: illegal op pulses out_err and emits zero
        send(6'd40, 5'd1, 5'd1, 5'd1, 32'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_err", {31'b0, bus.out_err}, 32'd1);
        check("t6_err_word", bus.out_data, 32'd0);
        @(negedge clk);
        check("t6_err_pulse", {31'b0, bus.out_err}, 32'd0);

        // 6: reset while HALF with a stalled word discards both
        bus.out_ready = 1'b0;
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0);
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_pre_rst", bus.out_data, 32'h0093_4095);
        rst_l = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("t6_rst_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        bus.out_ready = 1'b1;
        send(6'd12, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b0);
        expect_word("t6_post_rst", 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
